exe_result_stage: RTL and testbench
===================================

# exe_result_stage

Registered, parametrised execute-stage result selector for the pipelined MIPS datapath. Selects among ALU, shifter, SLT and HI/LO sources by function code, produces the zero flag for BEQ/BNE, and owns the HI/LO registers plus an unsigned MULTU unit. The multiplier is iterative by default, with a stall handshake. Sits between the EX functional units and the EX/MEM pipeline register.

## Interface
Parameters:
- WIDTH, 32, datapath width; applies to operands, result, HI and LO.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operation presented this cycle.
- funct  in  6  function code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SLL 000000, MULTU 011001, MFHI 010000, MFLO 010010, BEQ 000100, BNE 000101.
- alu_out  in  WIDTH  ALU result.
- shifter_out  in  WIDTH  shifter result.
- cout  in  1  carry-out of the ALU subtract, used for SLT.
- mul_a, mul_b  in  WIDTH  MULTU operands.
- busy  out  1  multiply in progress; upstream must hold its operation.
- out_valid  out  1  data_out/zero valid this cycle.
- data_out  out  WIDTH  selected result.
- zero  out  1  data_out == 0.

## Operation
- **Accept:** an operation is accepted on a rising edge when in_valid=1 and busy=0. When busy=1, in_valid is ignored, and upstream must keep funct and operands stable until acceptance.
- **Result selection (registered on acceptance):**
  - AND, OR, ADD, SUB, BEQ, BNE: data_out = alu_out.
  - SLT: data_out = {WIDTH-1 zeros, ~cout}.
  - SLL: data_out = shifter_out.
  - MFHI: data_out = HI.
  - MFLO: data_out = LO.
  - MULTU and any undefined funct: data_out = 0.
- zero = (selected value == 0), registered with data_out.
- **MULTU:** captures mul_a and mul_b at acceptance and computes the unsigned 2·WIDTH-bit product. HI gets the upper WIDTH bits; LO gets the lower WIDTH bits.
- **Iterative mode:** shift-add, one multiplier bit per cycle, tracked by a down-counter loaded with WIDTH.
- **Multiplier state machine:**
  - IDLE: busy=0. MULTU accepted → MUL.
  - MUL: busy=1. Each cycle performs one step and decrements the counter. At counter=1, writes HI/LO and returns to IDLE.
- HI/LO change only on MULTU completion and are never partially visible.

## Timing
- **Reset:** data_out=0, zero=0, out_valid=0, busy=0, HI=0, LO=0, multiplier state IDLE, counter 0.
- Latency is 1 cycle: an operation accepted at edge k has out_valid=1 with its data_out/zero during cycle k+1. out_valid=0 in any cycle following an edge with no acceptance.
- **MULTU accepted at edge k:**
  - out_valid=1, data_out=0, zero=1 in cycle k+1.
  - busy=1 from edge k through edge k+WIDTH; HI/LO are written at edge k+WIDTH.
  - busy=0 from cycle k+WIDTH+1.
  - An MFHI/MFLO accepted at edge k+WIDTH+1 returns the new value.
- Back-to-back MULTU: the second is accepted on the first edge after busy falls.
- Reset asserted mid-multiply aborts it: HI/LO=0 and busy=0 immediately (asynchronous).

## Configuration
- EXE_FAST_MULTU_EN defined:
  - MULTU computes the full product in the accepting cycle, and HI/LO are written at the accept edge.
  - busy stays 0 permanently; no counter or FSM is instantiated.
  - MFHI accepted on the very next edge returns the new HI.
- EXE_FAST_MULTU_EN undefined: iterative WIDTH-cycle multiplier as above.

## Test plan
- Reset, then ADD with alu_out=0x0000_0005 → next cycle out_valid=1, data_out=5, zero=0. SUB with alu_out=0 → data_out=0, zero=1.
- SLT with cout=0 → data_out=0x0000_0001. SLT with cout=1 → data_out=0, zero=1. SLL with shifter_out=0x8000_0000 → data_out=0x8000_0000.
- MULTU with mul_a=0xFFFF_FFFF, mul_b=0x0000_0002 (iterative mode):
  - busy high exactly 32 cycles; in_valid held during busy produces no accept.
  - Then MFHI → 0x0000_0001 and MFLO → 0xFFFF_FFFE.
- Undefined funct 111111 → data_out=0, zero=1, out_valid=1. Idle cycle (in_valid=0) → out_valid=0.
- Assert rst 10 cycles into a MULTU → busy=0 immediately; subsequent MFHI and MFLO both return 0.
- With EXE_FAST_MULTU_EN: MULTU 0x0001_0000 × 0x0001_0000, then MFHI on the next edge → 0x0000_0001; MFLO → 0; busy never asserts.

Source files
------------

// File: rtl/exe_result_stage.sv
// exe_result_stage: EX-stage result select, zero flag, HI/LO and MULTU unit (EXE_FAST_MULTU_EN selects a single-cycle multiplier)
module exe_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] shifter_out,
    input  logic             cout,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             zero
);
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_BEQ   = 6'b000100;
    localparam logic [5:0] F_BNE   = 6'b000101;

    logic             accept;
    logic             start_mul;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             out_valid_q, zero_q;

    assign accept    = in_valid && !busy;
    assign start_mul = accept && (funct == F_MULTU);

`ifdef EXE_FAST_MULTU_EN
    logic [2*WIDTH-1:0] prod;

    assign busy = 1'b0;
    assign prod = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};

    // whole product lands in HI/LO on the accepting edge
    always_comb begin
        hi_d = start_mul ? prod[2*WIDTH-1:WIDTH] : hi_q;
        lo_d = start_mul ? prod[WIDTH-1:0] : lo_q;
    end
`else
    typedef enum logic {IDLE, MUL} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    assign busy     = (state_q == MUL);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // shift-add multiplier: one multiplier bit per cycle, HI/LO written only on the last step
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: if (start_mul) begin
                state_d  = MUL;
                cnt_d    = CW'(WIDTH);
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, mul_a};
                mplier_d = mul_b;
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d      = IDLE;
                    {hi_d, lo_d} = acc_step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // multiplier state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`endif

    // result mux by function code; MULTU and undefined codes yield zero
    always_comb begin
        data_d = '0;
        case (funct)
            F_AND, F_OR, F_ADD, F_SUB, F_BEQ, F_BNE: data_d = alu_out;
            F_SLT:   data_d = {{(WIDTH-1){1'b0}}, ~cout};
            F_SLL:   data_d = shifter_out;
            F_MFHI:  data_d = hi_q;
            F_MFLO:  data_d = lo_q;
            default: data_d = '0;
        endcase
    end

    // HI/LO and registered result with its zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q        <= '0;
            lo_q        <= '0;
            data_q      <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= accept;
            if (accept) begin
                data_q <= data_d;
                zero_q <= (data_d == '0);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_exe_result_stage.sv
// tb_exe_result_stage: directed and random checks of exe_result_stage against a product-level model (EXE_FAST_MULTU_EN aware)
module tb_exe_result_stage;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_BEQ   = 6'b000100;
    localparam logic [5:0] F_BNE   = 6'b000101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] alu_out = '0, shifter_out = '0, mul_a = '0, mul_b = '0;
    logic        cout = 1'b0;
    logic        busy, out_valid, zero;
    logic [31:0] data_out;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    exe_result_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .funct(funct),
        .alu_out(alu_out), .shifter_out(shifter_out), .cout(cout),
        .mul_a(mul_a), .mul_b(mul_b), .busy(busy), .out_valid(out_valid),
        .data_out(data_out), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_sel(input logic [5:0] f, input logic [31:0] a, input logic [31:0] s, input logic c);
        if (f == F_AND || f == F_OR || f == F_ADD || f == F_SUB || f == F_BEQ || f == F_BNE) return a;
        if (f == F_SLT) return c ? 32'd0 : 32'd1;
        if (f == F_SLL) return s;
        if (f == F_MFHI) return m_hi;
        if (f == F_MFLO) return m_lo;
        return 32'd0;
    endfunction

    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] s, input logic c,
                         input logic [31:0] ma, input logic [31:0] mb);
        logic [31:0] exp;
        logic [63:0] p;
        int n;
        funct = f; alu_out = a; shifter_out = s; cout = c; mul_a = ma; mul_b = mb; in_valid = 1'b1;
        exp = model_sel(f, a, s, c);
        @(posedge clk); #1;
        chk("out_valid", out_valid, 1);
        chk("data_out", data_out, exp);
        chk("zero", zero, exp == 0);
        if (f == F_MULTU) begin
            p = ma * 64'(mb);
`ifdef EXE_FAST_MULTU_EN
            chk("busy_fast", busy, 0);
`else
            chk("busy_on", busy, 1);
            n = 0;
            while (busy === 1'b1 && n < 100) begin
                @(posedge clk); #1;
                n++;
                chk("no_accept_busy", out_valid, 0);
            end
            chk("busy_cycles", n, 32);
`endif
            m_hi = p[63:32];
            m_lo = p[31:0];
        end
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    logic [5:0] flist [12] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MULTU, F_MFHI, F_MFLO, F_BEQ, F_BNE, 6'b111111};

    initial begin
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_zero", zero, 0);
        chk("rst_busy", busy, 0);
        #10 rst = 1'b0;
        do_op(F_MFHI, 32'h1234, 0, 0, 0, 0);
        do_op(F_MFLO, 32'h1234, 0, 0, 0, 0);
        do_op(F_ADD, 32'h5, 0, 0, 0, 0);
        do_op(F_SUB, 32'h0, 0, 0, 0, 0);
        do_op(F_SLT, 32'h7, 0, 1'b0, 0, 0);
        do_op(F_SLT, 32'h7, 0, 1'b1, 0, 0);
        do_op(F_SLL, 32'h3, 32'h8000_0000, 0, 0, 0);
        do_op(F_MULTU, 32'h55, 0, 0, 32'hFFFF_FFFF, 32'h2);
        do_op(F_MFHI, 0, 0, 0, 0, 0);
        chk("mfhi_dir", data_out, 32'h1);
        do_op(F_MFLO, 0, 0, 0, 0, 0);
        chk("mflo_dir", data_out, 32'hFFFF_FFFE);
        do_op(6'b111111, 32'h9, 32'h9, 0, 0, 0);
        idle();
        do_op(F_MULTU, 0, 0, 0, 32'h0001_0000, 32'h0001_0000);
        do_op(F_MFHI, 0, 0, 0, 0, 0);
        do_op(F_MFLO, 0, 0, 0, 0, 0);
        do_op(F_MULTU, 0, 0, 0, 32'hDEAD_BEEF, 32'h1357_9BDF);
        do_op(F_MULTU, 0, 0, 0, 32'h8000_0001, 32'hFFFF_FFFF);
        do_op(F_MFHI, 0, 0, 0, 0, 0);
        do_op(F_MFLO, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            f = flist[$urandom_range(0, 11)];
            if ($urandom_range(0, 4) == 0) idle();
            do_op(f, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom, 1'($urandom),
                  $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom);
        end
        funct = F_MULTU; mul_a = 32'h1234_5678; mul_b = 32'h9ABC_DEF1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
`ifndef EXE_FAST_MULTU_EN
        chk("busy_mid", busy, 1);
`endif
        rst = 1'b1;
        #1;
        chk("busy_async_rst", busy, 0);
        chk("valid_async_rst", out_valid, 0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        do_op(F_MFHI, 0, 0, 0, 0, 0);
        do_op(F_MFLO, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
